axi_sim_console_slave: RTL and testbench
========================================

Name: axi_sim_console_slave

Overview:
AXI4 slave responder at the simulation console/status window (default 0x9000_0000). The CPU BIU is the write/read initiator. Single-beat writes to TXDATA deliver one character into a FIFO, drained by a valid/ready byte stream. Writes to EXIT latch a sticky done/exit code for the bench or SoC status pins. Sits on the SoC AXI fabric beside the main memory slave; synthesizable, 128-bit data path.

Parameters:
BASE_ADDR, 40'h00_9000_0000, window base; 16-byte window, addr[39:4] must match BASE_ADDR[39:4]
FIFO_DEPTH, 16, character FIFO entries; power of 2, >=2
ID_W, 8, AXI ID width

Ports:
clk  in  1  clock
rst_b  in  1  async active-low reset
awvalid/awready  in/out  1/1  write-address handshake
awid  in  ID_W  write ID
awaddr  in  40  write address
awlen  in  4  burst length-1
wvalid/wready  in/out  1/1  write-data handshake
wdata  in  128  write data
wstrb  in  16  byte strobes
wlast  in  1  last beat
bvalid/bready  out/in  1/1  write-response handshake
bid  out  ID_W  response ID (captured awid)
bresp  out  2  00 OKAY, 10 SLVERR
arvalid/arready  in/out  1/1  read-address handshake
arid  in  ID_W  read ID
araddr  in  40  read address
arlen  in  4  burst length-1
rvalid/rready  out/in  1/1  read-data handshake
rid  out  ID_W  read ID
rdata  out  128  read data
rresp  out  2  read response
rlast  out  1  always 1 with rvalid
char_valid/char_ready  out/in  1/1  console byte stream
char_data  out  8  FIFO head byte
sim_done  out  1  sticky: EXIT written
sim_pass  out  1  sim_done && exit_code==0
exit_code  out  32  last EXIT value

Behaviour:
- Reset (async, rst_b low): awready=1, arready=1; wready, bvalid, rvalid, char_valid, sim_done, sim_pass = 0; exit_code, bresp, rresp, rdata, bid, rid = 0; FIFO empty. Reset mid-transaction aborts it, with no B/R issued.
- Register map, offset addr[3:2]: 0 TXDATA (W), 1 EXIT (W), 2 STATUS (R), 3 reserved. Lane k corresponds to wstrb == 16'hF << 4k and data wdata[32k+31:32k].
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On aw handshake, capture id, addr, len; err = (awlen!=0) || window miss. Then awready=0.
  - W_DATA: wready=1, except when target is TXDATA, err=0 and the FIFO is full; then wready=0 until a pop frees an entry. There is no same-cycle pop bypass.
  - W_DATA, each accepted beat with err=0:
    - TXDATA with correct lane strobe: push wdata[32k+7:32k].
    - EXIT with correct lane strobe: exit_code<=lane word, sim_done<=1.
    - Wrong strobe or reserved/STATUS offset: no effect, OKAY.
  - err=1: drain all beats without side effects, bresp=SLVERR.
  - W_DATA exit: on the wlast beat go to W_RESP. wlast asserted early or late is not checked; the FSM counts awlen+1 beats and uses the count.
  - W_RESP: bvalid=1 the cycle after the last beat, held until bready, then W_IDLE.
  - Minimum write latency: aw at cycle 0, w at cycle 1, bvalid at cycle 2.
- Read FSM, R_IDLE -> R_DATA:
  - On ar handshake: arready=0; next cycle rvalid=1, rlast=1, rid=arid.
  - rresp = SLVERR if arlen!=0 or window miss; otherwise OKAY. Bursts are answered with a single beat plus SLVERR.
  - STATUS rdata lane 2 = {exit_code[15:0], 8'b0, fifo_count[5:0], sim_pass, sim_done}.
  - All other offsets read 0.
  - Hold rvalid until rready, then R_IDLE.
  - Read and write FSMs are independent and may run concurrently.
- FIFO:
  - Wrapping pointers with an extra wrap bit; count = wptr-rptr.
  - char_valid = !empty; char_data = mem[rptr].
  - Pop on char_valid&&char_ready.
  - Simultaneous push+pop: count unchanged. Pop-only when empty: impossible by construction.
- sim_done is sticky. A second EXIT write overwrites exit_code, and sim_pass recomputes combinationally from it.

Test Plan:
- Write 0x9000_0000, awlen=0, wstrb=16'h000F, wdata[7:0]=8'h41, char_ready=1 -> bvalid 2 cycles after aw with bresp=00; char_valid=1, char_data=8'h41; FIFO returns to empty.
- Back-to-back 17 TXDATA writes with char_ready=0 (FIFO_DEPTH=16) -> writes 1-16 get OKAY. On write 17, wready stays 0 until char_ready pulses once. Then write 17 completes, and 17 chars pop in order.
- Write 0x9000_0004, wstrb=16'h00F0, wdata[63:32]=0 -> sim_done=1, sim_pass=1. A second write with 32'h2382_3487 -> sim_pass=0, exit_code=32'h2382_3487, sim_done stays 1.
- awlen=3 burst to TXDATA -> 4 beats accepted, no FIFO push, bresp=10, bid=awid.
- Read 0x9000_0008 with 3 chars queued after a passing EXIT -> rdata[71:64] = {6'd3, 1, 1}; rresp=00, rlast=1, rid=arid. Read of 0xA000_0000 -> rresp=10.
- Assert rst_b low between aw handshake and the w beat -> no bvalid afterwards; awready=1; FIFO empty; sim_done=0.

Source files
------------

// File: rtl/axi_sim_console_slave.sv
// AXI4 console/status slave: TXDATA byte FIFO, sticky EXIT latch, STATUS readback.
// Single-beat register window; bursts and window misses answer SLVERR.
module axi_sim_console_slave #(
    parameter logic [39:0] BASE_ADDR  = 40'h00_9000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          ID_W       = 8
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] awid,
    input  logic [39:0]     awaddr,
    input  logic [3:0]      awlen,
    input  logic            wvalid,
    output logic            wready,
    input  logic [127:0]    wdata,
    input  logic [15:0]     wstrb,
    input  logic            wlast,
    output logic            bvalid,
    input  logic            bready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    input  logic            arvalid,
    output logic            arready,
    input  logic [ID_W-1:0] arid,
    input  logic [39:0]     araddr,
    input  logic [3:0]      arlen,
    output logic            rvalid,
    input  logic            rready,
    output logic [ID_W-1:0] rid,
    output logic [127:0]    rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            char_valid,
    input  logic            char_ready,
    output logic [7:0]      char_data,
    output logic            sim_done,
    output logic            sim_pass,
    output logic [31:0]     exit_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t r_wst, w_wst_nxt;
    rstate_t r_rst, w_rst_nxt;

    logic [ID_W-1:0] r_bid, r_rid;
    logic [1:0]      r_bresp, r_rresp, r_woff;
    logic            r_werr, r_done;
    logic [3:0]      r_wcnt;
    logic [31:0]     r_exit;
    logic [127:0]    r_rdata;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wptr, r_rptr;

    logic [AW:0]  w_count;
    logic         w_full, w_stall, w_wbeat, w_push, w_pop;
    logic         w_aw_err, w_ar_err;
    logic [31:0]  w_status;
    logic         w_unused;

    // wlast is ignored: the beat count from awlen decides the last beat
    assign w_unused = ^{wlast, wdata[127:64], wdata[31:8],
                        awaddr[1:0], araddr[1:0]};

    assign w_count    = r_wptr - r_rptr;
    assign w_full     = (w_count == DEPTH);
    assign char_valid = (w_count != '0);
    assign char_data  = r_mem[r_rptr[AW-1:0]];
    assign w_pop      = char_valid && char_ready;

    assign w_stall  = (r_woff == 2'd0) && !r_werr && w_full;
    assign w_wbeat  = wvalid && wready;
    assign w_push   = w_wbeat && !r_werr && (r_woff == 2'd0)
                      && (wstrb == 16'h000F);
    assign w_aw_err = (awlen != 4'd0) || (awaddr[39:4] != BASE_ADDR[39:4]);
    assign w_ar_err = (arlen != 4'd0) || (araddr[39:4] != BASE_ADDR[39:4]);

    assign sim_done  = r_done;
    assign exit_code = r_exit;
    assign sim_pass  = r_done && (r_exit == 32'd0);
    assign w_status  = {r_exit[15:0], 8'h00, 6'(w_count), sim_pass, sim_done};

    assign bid   = r_bid;
    assign bresp = r_bresp;
    assign rid   = r_rid;
    assign rresp = r_rresp;
    assign rdata = r_rdata;
    assign rlast = rvalid;

    // Write FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_wst <= W_IDLE;
        else        r_wst <= w_wst_nxt;
    end

    // Write FSM next state and handshake outputs
    always_comb begin
        w_wst_nxt = r_wst;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        unique case (r_wst)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_wst_nxt = W_DATA;
            end
            W_DATA: begin
                wready = !w_stall;
                if (wvalid && !w_stall && r_wcnt == 4'd0)
                    w_wst_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_wst_nxt = W_IDLE;
            end
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    // Write address capture and beat counting
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_bid   <= '0;
            r_bresp <= 2'b00;
            r_woff  <= 2'd0;
            r_werr  <= 1'b0;
            r_wcnt  <= 4'd0;
        end else if (awvalid && awready) begin
            r_bid   <= awid;
            r_bresp <= w_aw_err ? 2'b10 : 2'b00;
            r_woff  <= awaddr[3:2];
            r_werr  <= w_aw_err;
            r_wcnt  <= awlen;
        end else if (w_wbeat) begin
            r_wcnt  <= r_wcnt - 4'd1;
        end
    end

    // EXIT register: sticky done flag plus last exit code
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_done <= 1'b0;
            r_exit <= 32'd0;
        end else if (w_wbeat && !r_werr && r_woff == 2'd1
                     && wstrb == 16'h00F0) begin
            r_done <= 1'b1;
            r_exit <= wdata[63:32];
        end
    end

    // FIFO pointers; wrap bit distinguishes full from empty
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // FIFO storage needs no reset; only entries below wptr are ever read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata[7:0];
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_rst <= R_IDLE;
        else        r_rst <= w_rst_nxt;
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        w_rst_nxt = r_rst;
        arready   = 1'b0;
        rvalid    = 1'b0;
        unique case (r_rst)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) w_rst_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) w_rst_nxt = R_IDLE;
            end
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    // Read response captured at the address handshake
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rid   <= '0;
            r_rresp <= 2'b00;
            r_rdata <= '0;
        end else if (arvalid && arready) begin
            r_rid   <= arid;
            r_rresp <= w_ar_err ? 2'b10 : 2'b00;
            r_rdata <= (!w_ar_err && araddr[3:2] == 2'd2)
                       ? {32'd0, w_status, 64'd0} : 128'd0;
        end
    end

endmodule

// File: tb/tb_axi_sim_console_slave.sv
// Bench for axi_sim_console_slave: vector table, directed corner cases,
// and random traffic against a queue/register reference model.
module tb_axi_sim_console_slave;

    localparam logic [39:0] BASE = 40'h00_9000_0000;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         awvalid = 0, awready;
    logic [7:0]   awid = 0;
    logic [39:0]  awaddr = 0;
    logic [3:0]   awlen = 0;
    logic         wvalid = 0, wready;
    logic [127:0] wdata = 0;
    logic [15:0]  wstrb = 0;
    logic         wlast = 0;
    logic         bvalid, bready = 0;
    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         arvalid = 0, arready;
    logic [7:0]   arid = 0;
    logic [39:0]  araddr = 0;
    logic [3:0]   arlen = 0;
    logic         rvalid, rready = 0;
    logic [7:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         char_valid, char_ready = 0;
    logic [7:0]   char_data;
    logic         sim_done, sim_pass;
    logic [31:0]  exit_code;

    always #5 clk = ~clk;

    axi_sim_console_slave #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(16), .ID_W(8)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .awvalid(awvalid), .awready(awready), .awid(awid),
        .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid),
        .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .char_valid(char_valid), .char_ready(char_ready),
        .char_data(char_data),
        .sim_done(sim_done), .sim_pass(sim_pass), .exit_code(exit_code)
    );

    // reference model
    logic [7:0]  m_q[$];
    logic [31:0] m_exit = 0;
    logic        m_done = 0;
    bit          rand_rdy = 0;
    int          n_pops = 0;
    int          n_pass = 0;
    int          n_tot = 0;

    typedef struct {
        bit           rd;
        logic [39:0]  a;
        logic [3:0]   len;
        logic [15:0]  s;
        logic [127:0] d;
        logic [1:0]   resp;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    // advance one cycle; check any pop that the coming edge performs
    task automatic step();
        if (char_valid && char_ready) begin
            if (m_q.size() == 0) begin
                chk("char_unexpected", char_valid, 1'b0);
            end else begin
                chk("char_order", char_data, m_q[0]);
                void'(m_q.pop_front());
                n_pops++;
            end
        end
        @(negedge clk);
        if (rand_rdy) char_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_beat(input bit err, input logic [1:0] off,
                              input logic [15:0] s, input logic [127:0] d);
        if (!err) begin
            if (off == 2'd0 && s == 16'h000F) m_q.push_back(d[7:0]);
            else if (off == 2'd1 && s == 16'h00F0) begin
                m_exit = d[63:32];
                m_done = 1'b1;
            end
        end
    endtask

    task automatic do_write(input logic [39:0] a, input logic [7:0] id,
                            input logic [3:0] len, input logic [127:0] d,
                            input logic [15:0] s, output logic [1:0] br,
                            output logic [7:0] bi, output int lat);
        int n;
        bit err;
        err = (len != 0) || (a[39:4] != BASE[39:4]);
        awvalid = 1; awaddr = a; awid = id; awlen = len;
        n = 0;
        while (!awready && n < 50) begin step(); n++; end
        chk("aw_ready", awready, 1'b1);
        step();
        awvalid = 0;
        lat = 1;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1; wdata = d; wstrb = s; wlast = (b == int'(len));
            n = 0;
            while (!wready && n < 200) begin step(); n++; lat++; end
            chk("w_ready", wready, 1'b1);
            model_beat(err, a[3:2], s, d);
            step();
            lat++;
        end
        wvalid = 0; wlast = 0; bready = 1;
        n = 0;
        while (!bvalid && n < 50) begin step(); n++; lat++; end
        chk("b_valid", bvalid, 1'b1);
        chk("b_resp", bresp, err ? 2'b10 : 2'b00);
        chk("b_id", bid, id);
        br = bresp;
        bi = bid;
        step();
        bready = 0;
    endtask

    task automatic do_read(input logic [39:0] a, input logic [7:0] id,
                           input logic [3:0] len, output logic [127:0] rd,
                           output logic [1:0] rr);
        int n;
        bit err;
        logic [127:0] exp_rd;
        err = (len != 0) || (a[39:4] != BASE[39:4]);
        arvalid = 1; araddr = a; arid = id; arlen = len;
        n = 0;
        while (!arready && n < 50) begin step(); n++; end
        chk("ar_ready", arready, 1'b1);
        exp_rd = '0;
        if (!err && a[3:2] == 2'd2)
            exp_rd[95:64] = {m_exit[15:0], 8'h00, 6'(m_q.size()),
                             m_done && (m_exit == 0), m_done};
        step();
        arvalid = 0; rready = 1;
        n = 0;
        while (!rvalid && n < 50) begin step(); n++; end
        chk("r_valid", rvalid, 1'b1);
        chk("r_resp", rresp, err ? 2'b10 : 2'b00);
        chk("r_id", rid, id);
        chk("r_last", rlast, 1'b1);
        chk("r_data", rdata, exp_rd);
        rd = rdata;
        rr = rresp;
        step();
        rready = 0;
    endtask

    task automatic drain();
        int n;
        char_ready = 1;
        n = 0;
        while (m_q.size() > 0 && n < 200) begin step(); n++; end
        chk("drain_empty", char_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]   br, rr;
        logic [7:0]   bi;
        logic [127:0] rd;
        logic [39:0]  a;
        logic [3:0]   len;
        logic [15:0]  s;
        logic [127:0] d;
        int           lat, p0, n;

        tbl[0]  = '{0, BASE,                  4'd0, 16'h000F, 128'h41,             2'b00};
        tbl[1]  = '{0, 40'h00_A000_0000,      4'd0, 16'h000F, 128'h42,             2'b10};
        tbl[2]  = '{0, BASE + 40'd12,         4'd0, 16'hF000, 128'h0,              2'b00};
        tbl[3]  = '{0, BASE + 40'd8,          4'd0, 16'h0F00, 128'h0,              2'b00};
        tbl[4]  = '{0, BASE,                  4'd0, 16'h00F0, 128'h43,             2'b00};
        tbl[5]  = '{0, BASE + 40'd4,          4'd0, 16'h00F0, 128'h1234_0000_0000, 2'b00};
        tbl[6]  = '{1, BASE + 40'd8,          4'd0, 16'h0,    128'h0,              2'b00};
        tbl[7]  = '{1, BASE,                  4'd0, 16'h0,    128'h0,              2'b00};
        tbl[8]  = '{1, BASE + 40'd8,          4'd2, 16'h0,    128'h0,              2'b10};
        tbl[9]  = '{1, BASE + 40'd16,         4'd0, 16'h0,    128'h0,              2'b10};
        tbl[10] = '{0, BASE + 40'd16,         4'd0, 16'h000F, 128'h44,             2'b10};

        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_char_valid", char_valid, 1'b0);
        chk("rst_sim_done", sim_done, 1'b0);
        chk("rst_sim_pass", sim_pass, 1'b0);
        chk("rst_exit_code", exit_code, 32'd0);
        chk("rst_rdata", rdata, 128'd0);
        chk("rst_bresp_rresp", {bresp, rresp}, 4'd0);
        rst_b = 1;
        @(negedge clk);

        // single TXDATA write: latency 2, char appears and is drained
        char_ready = 1;
        p0 = n_pops;
        do_write(BASE, 8'h11, 4'd0, 128'h41, 16'h000F, br, bi, lat);
        chk("tx_latency", lat, 2);
        chk("tx_bresp", br, 2'b00);
        chk("tx_popped", n_pops - p0, 1);
        chk("tx_fifo_empty", char_valid, 1'b0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rd) begin
                do_read(tbl[i].a, 8'(i), tbl[i].len, rd, rr);
                chk($sformatf("tbl%0d_resp", i), rr, tbl[i].resp);
            end else begin
                do_write(tbl[i].a, 8'(i), tbl[i].len, tbl[i].d, tbl[i].s,
                         br, bi, lat);
                chk($sformatf("tbl%0d_resp", i), br, tbl[i].resp);
            end
        end
        chk("tbl_exit_code", exit_code, 32'h1234);
        chk("tbl_done_pass", {sim_done, sim_pass}, 2'b10);

        // fill the FIFO, then a 17th write must stall until one pop
        char_ready = 0;
        p0 = n_pops;
        for (int i = 0; i < 16; i++)
            do_write(BASE, 8'(i), 4'd0, 128'(8'h50 + i), 16'h000F,
                     br, bi, lat);
        awvalid = 1; awaddr = BASE; awlen = 0; awid = 8'h77;
        step();
        awvalid = 0;
        wvalid = 1; wdata = 128'h60; wstrb = 16'h000F; wlast = 1;
        for (int k = 0; k < 4; k++) begin
            chk("full_wready_low", wready, 1'b0);
            step();
        end
        char_ready = 1;
        step();
        char_ready = 0;
        chk("full_wready_freed", wready, 1'b1);
        model_beat(1'b0, 2'd0, 16'h000F, 128'h60);
        step();
        wvalid = 0; wlast = 0; bready = 1;
        n = 0;
        while (!bvalid && n < 50) begin step(); n++; end
        chk("full_bresp", {bvalid, bresp}, 3'b100);
        chk("full_bid", bid, 8'h77);
        step();
        bready = 0;
        drain();
        chk("full_pop_count", n_pops - p0, 17);

        // EXIT: pass, then a failing code overwrites it
        do_write(BASE + 40'd4, 8'h21, 4'd0, 128'h0, 16'h00F0, br, bi, lat);
        chk("exit0_done_pass", {sim_done, sim_pass}, 2'b11);
        do_write(BASE + 40'd4, 8'h22, 4'd0, 128'h2382_3487_0000_0000,
                 16'h00F0, br, bi, lat);
        chk("exit1_done_pass", {sim_done, sim_pass}, 2'b10);
        chk("exit1_code", exit_code, 32'h2382_3487);

        // burst to TXDATA: all beats drained, no push, SLVERR
        char_ready = 0;
        do_write(BASE, 8'h5A, 4'd3, 128'h42, 16'h000F, br, bi, lat);
        chk("burst_bresp", br, 2'b10);
        chk("burst_bid", bi, 8'h5A);
        chk("burst_no_push", char_valid, 1'b0);

        // STATUS with 3 chars queued after a passing EXIT
        do_write(BASE + 40'd4, 8'h23, 4'd0, 128'h0, 16'h00F0, br, bi, lat);
        for (int i = 0; i < 3; i++)
            do_write(BASE, 8'h30, 4'd0, 128'(8'h61 + i), 16'h000F,
                     br, bi, lat);
        do_read(BASE + 40'd8, 8'h3C, 4'd0, rd, rr);
        chk("status_lane", rd[71:64], 8'h0F);
        chk("status_rresp", rr, 2'b00);
        do_read(40'h00_A000_0000, 8'h3D, 4'd0, rd, rr);
        chk("miss_rresp", rr, 2'b10);
        drain();

        // random traffic against the model
        rand_rdy = 1;
        for (int k = 0; k < 300; k++) begin
            a = ($urandom_range(0, 7) == 0)
                ? 40'h00_A000_0000 + 40'($urandom_range(0, 3) * 4)
                : BASE + 40'($urandom_range(0, 3) * 4);
            len = ($urandom_range(0, 5) == 0)
                  ? 4'($urandom_range(1, 15)) : 4'd0;
            case ($urandom_range(0, 4))
                0: s = 16'h000F;
                1: s = 16'h00F0;
                2: s = 16'h0F00;
                3: s = 16'hF000;
                default: s = 16'($urandom);
            endcase
            d = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d[63:32] = 32'd0;
            if ($urandom_range(0, 2) == 0)
                do_read(a, 8'($urandom), len, rd, rr);
            else
                do_write(a, 8'($urandom), len, d, s, br, bi, lat);
        end
        rand_rdy = 0;
        drain();
        chk("rand_exit_code", exit_code, m_exit);
        chk("rand_done_pass", {sim_done, sim_pass},
            {m_done, m_done && (m_exit == 0)});

        // reset between AW and W aborts the write
        char_ready = 0;
        do_write(BASE, 8'h01, 4'd0, 128'h5A, 16'h000F, br, bi, lat);
        awvalid = 1; awaddr = BASE + 40'd4; awlen = 0; awid = 8'h09;
        step();
        awvalid = 0;
        chk("pre_rst_wready", wready, 1'b1);
        rst_b = 0;
        m_q.delete();
        m_exit = 0;
        m_done = 0;
        #1;
        chk("async_rst_awready", awready, 1'b1);
        step();
        rst_b = 1;
        wvalid = 1; wdata = 128'h0; wstrb = 16'h00F0; wlast = 1;
        bready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_no_bvalid", bvalid, 1'b0);
            step();
        end
        wvalid = 0; wlast = 0; bready = 0;
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_fifo_empty", char_valid, 1'b0);
        chk("post_rst_sim_done", sim_done, 1'b0);
        chk("post_rst_exit_code", exit_code, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
